// File: rtl/tone_gen.sv
// tone_gen: note-select square-wave generator with an iterative divider.
// Define TONE_GEN_OCTAVE_EN to apply the octave left-shift to the base pitch.
module tone_gen #(
  parameter int CLK_HZ = 50000000,
  parameter int CNT_W  = 32,
  parameter int OCT_W  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       note_sel,
  input  logic [OCT_W-1:0] octave,
  input  logic             note_valid,
  output logic             ready,
  input  logic             enable,
  output logic             tone_out,
  output logic [CNT_W-1:0] freq_hz,
  output logic             done
);

  localparam int BW = $clog2(CNT_W) + 1;

  typedef enum logic [1:0] {IDLE, DIV, RUN} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] divisor;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] quo;
  logic [BW-1:0]    bit_cnt;
  logic [CNT_W-1:0] half_period;
  logic [CNT_W-1:0] cnt;

  logic [CNT_W-1:0] base;
  logic [CNT_W-1:0] freq_calc;
  logic [CNT_W-1:0] div_calc;
  logic [CNT_W:0]   rem_sh;
  logic             fits;
  logic [CNT_W-1:0] rem_nx;
  logic [CNT_W-1:0] quo_nx;
  logic [CNT_W-1:0] q_final;
  logic             accept;
  logic             last;

  // Base pitch table for the eight scale degrees.
  always_comb begin
    base = CNT_W'(523);
    unique case (note_sel)
      3'd0: base = CNT_W'(523);
      3'd1: base = CNT_W'(587);
      3'd2: base = CNT_W'(659);
      3'd3: base = CNT_W'(698);
      3'd4: base = CNT_W'(783);
      3'd5: base = CNT_W'(880);
      3'd6: base = CNT_W'(987);
      3'd7: base = CNT_W'(1046);
    endcase
  end

`ifdef TONE_GEN_OCTAVE_EN
  localparam int SW = CNT_W + (1 << OCT_W);
  logic [SW-1:0] wide;
  assign wide      = SW'(base) << octave;
  assign freq_calc = (|wide[SW-1:CNT_W]) ? '1 : wide[CNT_W-1:0];
`else
  logic unused_octave;
  assign unused_octave = ^octave;
  assign freq_calc     = base;
`endif

  // Twice the pitch gives one half-period per quotient; saturate on overflow.
  assign div_calc = freq_calc[CNT_W-1] ? '1
                                       : {freq_calc[CNT_W-2:0], 1'b0};

  // One restoring-division step: shift in the next dividend bit, try subtract.
  assign rem_sh  = {rem, quo[CNT_W-1]};
  assign fits    = rem_sh >= {1'b0, divisor};
  assign rem_nx  = fits ? CNT_W'(rem_sh - {1'b0, divisor})
                        : rem_sh[CNT_W-1:0];
  assign quo_nx  = {quo[CNT_W-2:0], fits};
  assign q_final = (quo_nx == '0) ? CNT_W'(1) : quo_nx;

  assign ready  = (state != DIV);
  assign accept = note_valid && ready;
  assign last   = (bit_cnt == BW'(CNT_W - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (accept) state_n = DIV;
      DIV:  if (last)   state_n = RUN;
      RUN:  if (accept) state_n = DIV;
      default: state_n = IDLE;
    endcase
  end

  // Divider, half-period load and tone counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      freq_hz     <= '0;
      divisor     <= '0;
      rem         <= '0;
      quo         <= '0;
      bit_cnt     <= '0;
      half_period <= '0;
      cnt         <= '0;
      tone_out    <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        freq_hz  <= freq_calc;
        divisor  <= div_calc;
        rem      <= '0;
        quo      <= CNT_W'(CLK_HZ);
        bit_cnt  <= '0;
        cnt      <= '0;
        tone_out <= 1'b0;
      end else begin
        unique case (state)
          DIV: begin
            rem     <= rem_nx;
            quo     <= quo_nx;
            bit_cnt <= bit_cnt + 1'b1;
            if (last) begin
              half_period <= q_final;
              done        <= 1'b1;
              cnt         <= '0;
              tone_out    <= 1'b0;
            end
          end
          RUN: begin
            // The done cycle is the reload cycle; counting starts after it.
            if (!enable || done) begin
              cnt      <= '0;
              tone_out <= 1'b0;
            end else if (cnt == half_period - 1'b1) begin
              cnt      <= '0;
              tone_out <= ~tone_out;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            cnt      <= '0;
            tone_out <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tone_gen.sv
// tb_tone_gen: directed table-driven bench for tone_gen at CLK_HZ=1 MHz.
// Expected values follow TONE_GEN_OCTAVE_EN if it is defined for the build.
module tb_tone_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  note_sel;
  logic [1:0]  octave;
  logic        note_valid;
  logic        ready;
  logic        enable;
  logic        tone_out;
  logic [31:0] freq_hz;
  logic        done;

  int checks = 0;
  int errors = 0;

  tone_gen #(
    .CLK_HZ(1000000),
    .CNT_W (32),
    .OCT_W (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .note_sel  (note_sel),
    .octave    (octave),
    .note_valid(note_valid),
    .ready     (ready),
    .enable    (enable),
    .tone_out  (tone_out),
    .freq_hz   (freq_hz),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] note;
    logic [1:0] oct;
    logic       poke;
    int         freq;
    int         hp;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input longint act,
                       input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Accept a note and follow it through DIV and two tone rises.
  task automatic run_row(input vec_t v, input int idx);
    int low, dones, first, second, budget;
    logic tone_div, prev;
    low = 0; dones = 0; first = -1; second = -1;
    tone_div = 1'b0; prev = 1'b0;
    budget = 3 * v.hp + 80;
    @(negedge clk);
    note_sel = v.note; octave = v.oct; note_valid = 1'b1;
    @(negedge clk);
    note_valid = 1'b0;
    for (int i = 0; i <= budget; i++) begin
      if (!ready) low++;
      if (done) dones++;
      if (!ready && tone_out) tone_div = 1'b1;
      if (tone_out && !prev) begin
        if (first < 0) first = i;
        else second = i;
      end
      prev = tone_out;
      if (v.poke) begin
        note_valid = (i >= 3 && i <= 6);
        note_sel   = 3'd7;
      end
      if (second >= 0) break;
      @(negedge clk);
    end
    note_valid = 1'b0;
    check($sformatf("row%0d ready_low", idx), low, 32);
    check($sformatf("row%0d done_pulses", idx), dones, 1);
    check($sformatf("row%0d freq_hz", idx), freq_hz, v.freq);
    check($sformatf("row%0d half_period", idx), dut.half_period, v.hp);
    check($sformatf("row%0d tone_in_div", idx), tone_div, 0);
    check($sformatf("row%0d first_rise", idx), first, 33 + v.hp);
    check($sformatf("row%0d period", idx),
          (second < 0) ? -1 : second - first, 2 * v.hp);
  endtask

  initial begin
    int k;
    logic seen_hi, seen_cnt, seen_done, seen_low;

`ifdef TONE_GEN_OCTAVE_EN
    vecs[0] = '{3'd0, 2'd0, 1'b0, 523,  956};
    vecs[1] = '{3'd0, 2'd1, 1'b0, 1046, 478};
    vecs[2] = '{3'd7, 2'd0, 1'b0, 1046, 478};
    vecs[3] = '{3'd3, 2'd0, 1'b1, 698,  716};
    vecs[4] = '{3'd5, 2'd3, 1'b0, 7040, 71};
    vecs[5] = '{3'd6, 2'd2, 1'b0, 3948, 126};
`else
    vecs[0] = '{3'd0, 2'd0, 1'b0, 523,  956};
    vecs[1] = '{3'd0, 2'd1, 1'b0, 523,  956};
    vecs[2] = '{3'd7, 2'd0, 1'b0, 1046, 478};
    vecs[3] = '{3'd3, 2'd0, 1'b1, 698,  716};
    vecs[4] = '{3'd5, 2'd3, 1'b0, 880,  568};
    vecs[5] = '{3'd6, 2'd2, 1'b0, 987,  506};
`endif

    reset = 1'b1; note_sel = '0; octave = '0;
    note_valid = 1'b0; enable = 1'b1;
    repeat (3) @(negedge clk);
    check("rst ready", ready, 1);
    check("rst tone", tone_out, 0);
    check("rst done", done, 0);
    check("rst freq", freq_hz, 0);
    check("rst half_period", dut.half_period, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("idle tone", tone_out, 0);
    check("idle ready", ready, 1);

    for (int r = 0; r < 6; r++) run_row(vecs[r], r);
    run_row(vecs[0], 6);

    @(negedge clk);
    enable = 1'b0;
    seen_hi = 1'b0; seen_cnt = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tone_out) seen_hi = 1'b1;
      if (dut.cnt != 0) seen_cnt = 1'b1;
    end
    check("gate tone", seen_hi, 0);
    check("gate cnt", seen_cnt, 0);
    enable = 1'b1;
    k = 0;
    while (k < 2000) begin
      @(negedge clk);
      k++;
      if (tone_out) break;
    end
    check("reenable rise", k, 956);

    @(negedge clk);
    note_sel = 3'd1; octave = 2'd0; note_valid = 1'b1;
    @(negedge clk);
    note_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("middiv ready", ready, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("divrst ready", ready, 1);
    check("divrst freq", freq_hz, 0);
    check("divrst half_period", dut.half_period, 0);
    check("divrst tone", tone_out, 0);
    check("divrst done", done, 0);
    seen_done = 1'b0; seen_low = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
      if (!ready) seen_low = 1'b1;
    end
    check("divrst no_done", seen_done, 0);
    check("divrst stays_idle", seen_low, 0);

    reset = 1'b1; note_valid = 1'b1; note_sel = 3'd2;
    @(negedge clk);
    reset = 1'b0; note_valid = 1'b0;
    check("prio ready", ready, 1);
    check("prio freq", freq_hz, 0);
    @(negedge clk);
    check("prio no_accept", ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tone_gen.md
TONE_GEN -- requirements
Module: tone_gen

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 SHALL have parameter CNT_W, default 32, width of the divider, half-period register and counters.
REQ-003 SHALL have parameter OCT_W, default 2, width of the octave shift input.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port note_sel  input  3  scale degree: 0=DO 523, 1=RE 587, 2=MI 659, 3=FA 698, 4=SOL 783, 5=LA 880, 6=SI 987, 7=DO2 1046 (Hz).
REQ-007 SHALL have port octave  input  OCT_W  left-shift applied to the base frequency.
REQ-008 SHALL have port note_valid  input  1  request to load note_sel/octave.
REQ-009 SHALL have port ready  output  1  high when a note_valid will be accepted.
REQ-010 SHALL have port enable  input  1  audio gate.
REQ-011 SHALL have port tone_out  output  1  square-wave output.
REQ-012 SHALL have port freq_hz  output  CNT_W  frequency of the loaded note.
REQ-013 SHALL have port done  output  1  one-cycle pulse when a new half-period is loaded.

Function
REQ-014 SHALL implement FSM states IDLE, DIV, RUN.
REQ-015 ready SHALL be 1 in IDLE and RUN and 0 in DIV.
REQ-016 Accept SHALL occur when note_valid && ready; note_valid while ready=0 SHALL be ignored, with no queuing.
REQ-017 On accept, freq_hz SHALL be set to base(note_sel) << octave, the divisor SHALL be set to 2*freq_hz, and the FSM SHALL enter DIV.
REQ-018 DIV SHALL be an iterative restoring divide of CLK_HZ by the divisor, one quotient bit per cycle, lasting exactly CNT_W cycles.
REQ-019 The quotient SHALL be truncated; a quotient of 0 SHALL be clamped to 1.
REQ-020 On DIV exit, the quotient SHALL load half_period, done SHALL pulse for 1 cycle, the period counter SHALL clear to 0, tone_out SHALL clear to 0, and the FSM SHALL enter RUN.
REQ-021 First tone_out high SHALL occur CNT_W+1 cycles after the accept edge plus half_period cycles.
REQ-022 In RUN with enable=1, the counter SHALL increment each cycle; at half_period-1 the counter SHALL wrap to 0 and tone_out SHALL toggle.
REQ-023 Output period SHALL be 2*half_period cycles.
REQ-024 With enable=0, tone_out SHALL be 0 and the counter SHALL be held at 0; the FSM and accepts SHALL be unaffected.
REQ-025 When enable rises, counting SHALL restart from 0 with tone_out=0.
REQ-026 An accept in RUN SHALL stop the tone (tone_out=0) for the whole of DIV, then resume at the new pitch.
REQ-027 In IDLE, tone_out SHALL be 0 regardless of enable.
REQ-028 Divisor width SHALL be CNT_W; the shift SHALL saturate to all-ones on overflow.

Reset
REQ-029 On reset=1 at a clock edge, from any state including mid-DIV, the block SHALL go to IDLE with ready=1, tone_out=0, done=0, freq_hz=0, half_period=0 and counter=0.
REQ-030 reset SHALL have priority over note_valid in the same cycle.

Configuration
REQ-031 With macro TONE_GEN_OCTAVE_EN defined, octave SHALL be applied per REQ-017.
REQ-032 Without TONE_GEN_OCTAVE_EN, the octave port SHALL remain present but be ignored (shift 0), and no shifter logic SHALL be built.

Verification (CLK_HZ=1000000, CNT_W=32, macro defined)
REQ-033 Bench SHALL check: reset, then note_sel=0, octave=0, note_valid for 1 cycle -> ready low 32 cycles, done pulse, freq_hz=523, half_period=956, tone_out period 1912 cycles.
REQ-034 Bench SHALL check: note_sel=0, octave=1 -> freq_hz=1046, half_period=478; note_sel=7, octave=0 -> identical half_period 478.
REQ-035 Bench SHALL check: note_valid pulses during DIV -> ignored; freq_hz unchanged until the next accept.
REQ-036 Bench SHALL check: enable dropped in RUN for 100 cycles -> tone_out=0 throughout; on re-enable, first rise after 956 cycles (DO).
REQ-037 Bench SHALL check: reset asserted 10 cycles into DIV -> next cycle IDLE, ready=1, freq_hz=0, no done pulse.
REQ-038 Bench SHALL check: macro undefined, note_sel=5, octave=3 -> freq_hz=880, half_period=568.
